// File: rtl/permutation_ctrl_pkg.sv
// ============================================================================
// permutation_ctrl_pkg : shared types and constants for the permutation
// sequencing controller.   Rev 1.0
// ============================================================================
`default_nettype none

package permutation_ctrl_pkg;

    typedef logic [3:0] type_round;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } type_perm_state;

    localparam type_round ROUND_LAST = 4'd11;

    // First round index of a variant that ends on round 'last'.
    function automatic type_round start_index(input int last, input int nb_rounds);
        return type_round'(last + 1 - nb_rounds);
    endfunction

endpackage

`default_nettype wire

// File: rtl/permutation_ctrl_if.sv
// ============================================================================
// permutation_ctrl_if : start handshake plus datapath control bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

interface permutation_ctrl_if;
    import permutation_ctrl_pkg::*;

    logic      start_i;
    logic      mode_i;
    logic      ready_o;
    logic      select_o;
    logic      enable_o;
    type_round round_o;
    logic      done_o;

    modport master (
        output start_i, mode_i,
        input  ready_o, select_o, enable_o, round_o, done_o
    );

    modport slave (
        input  start_i, mode_i,
        output ready_o, select_o, enable_o, round_o, done_o
    );
endinterface

`default_nettype wire

// File: rtl/permutation_ctrl_round_counter.sv
// ============================================================================
// permutation_ctrl_round_counter : loadable 4-bit round counter that saturates
// at the final round index.   Rev 1.0
// ============================================================================
`default_nettype none

module permutation_ctrl_round_counter
    import permutation_ctrl_pkg::*;
#(
    parameter type_round LAST = ROUND_LAST
) (
    input  wire logic       clock_i,
    input  wire logic       reset_i,
    input  wire logic       load_i,
    input  wire logic [3:0] load_val_i,
    input  wire logic       en_i,
    output logic      [3:0] count_o,
    output logic            last_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Saturate instead of wrapping so the round index can never run past LAST.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q < LAST)) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST);

    a_no_overrun: assert property (@(posedge clock_i) disable iff (reset_i) count_q <= LAST);

endmodule

`default_nettype wire

// File: rtl/permutation_ctrl.sv
// ============================================================================
// permutation_ctrl : sequences init-select, register-enable and round index
// of the permutation datapath for p12 / p6.   Rev 1.0
// ============================================================================
`default_nettype none

module permutation_ctrl #(
    parameter int ROUND_LAST  = 11,
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input wire logic          clock_i,
    input wire logic          reset_i,
    permutation_ctrl_if.slave bus
);
    import permutation_ctrl_pkg::*;

    localparam type_round START_A = start_index(ROUND_LAST, NB_ROUNDS_A);
    localparam type_round START_B = start_index(ROUND_LAST, NB_ROUNDS_B);

    type_perm_state state_q;
    type_perm_state state_d;

    logic      cnt_load;
    logic      cnt_inc;
    logic      cnt_last;
    type_round cnt_load_val;
    type_round cnt_value;

    permutation_ctrl_round_counter #(
        .LAST (type_round'(ROUND_LAST))
    ) u_round_counter (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_inc),
        .count_o    (cnt_value),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start_i is only looked at in IDLE and DONE; mode is captured purely
    // through the counter load value, so mid-run mode changes cannot leak in.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;
        cnt_load_val = bus.mode_i ? START_A : START_B;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    cnt_load = 1'b1;
                    state_d  = FIRST;
                end
            end
            FIRST, RUN: begin
                if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.start_i) begin
                    cnt_load = 1'b1;
                    state_d  = FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_o  = (state_q == IDLE) || (state_q == DONE);
    assign bus.select_o = (state_q == FIRST);
    assign bus.enable_o = (state_q == FIRST) || (state_q == RUN);
    assign bus.done_o   = (state_q == DONE);
    assign bus.round_o  = cnt_value;

endmodule

`default_nettype wire

// File: tb/tb_permutation_ctrl.sv
// ============================================================================
// tb_permutation_ctrl : directed bench for permutation_ctrl with a
// per-cycle expected-output model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_permutation_ctrl;

    typedef struct {
        logic       ready;
        logic       sel;
        logic       en;
        logic       done;
        logic [3:0] round;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    permutation_ctrl_if bus ();

    permutation_ctrl dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int   n_pass = 0;
    int   n_total = 0;
    logic chk_en = 1'b0;
    logic model_ready = 1'b1;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Model: an accepted start schedules one cycle per round, then a done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            model_ready = 1'b1;
        end else if (chk_en && model_ready && bus.start_i) begin
            int first;
            first = bus.mode_i ? 0 : 6;
            for (int r = first; r <= 11; r++)
                exp_q.push_back('{ready: 1'b0, sel: (r == first), en: 1'b1, done: 1'b0, round: 4'(r)});
            exp_q.push_back('{ready: 1'b1, sel: 1'b0, en: 1'b0, done: 1'b1, round: 4'd0});
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            exp_t e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{ready: 1'b1, sel: 1'b0, en: 1'b0, done: 1'b0, round: 4'd0};
            model_ready = e.ready;
            chk("cyc_ready", bus.ready_o, e.ready);
            chk("cyc_select", bus.select_o, e.sel);
            chk("cyc_enable", bus.enable_o, e.en);
            chk("cyc_done", bus.done_o, e.done);
            if (e.en) chk("cyc_round", bus.round_o, e.round);
        end
    end

    // Caller sits just after a rising edge; returns in cycle 1 of the run.
    task automatic launch(input logic mode);
        bus.start_i = 1'b1;
        bus.mode_i  = mode;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic measure(input logic poke, input logic b2b, output int lat, output int nr,
                           output int nsel, output logic [3:0] r_first, output logic [3:0] r_last);
        lat = 0; nr = 0; nsel = 0; r_first = 4'hF; r_last = 4'hF;
        for (int i = 1; i <= 40; i++) begin
            bus.start_i = 1'b0;
            if (poke && bus.enable_o && bus.round_o == 4'd4) begin
                bus.start_i = 1'b1;
                bus.mode_i  = ~bus.mode_i;
            end
            if (bus.enable_o) begin
                if (nr == 0) r_first = bus.round_o;
                r_last = bus.round_o;
                nr++;
                if (bus.select_o) nsel++;
            end
            if (bus.done_o) begin
                lat = i;
                if (b2b) begin
                    bus.start_i = 1'b1;
                    bus.mode_i  = 1'b0;
                end
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat, nr, nsel;
        logic [3:0] rf, rl;
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;

        // Reset asserted between edges must act immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", bus.ready_o, 1'b1);
        chk("rst_select", bus.select_o, 1'b0);
        chk("rst_enable", bus.enable_o, 1'b0);
        chk("rst_round", bus.round_o, 4'd0);
        chk("rst_done", bus.done_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // p12
        launch(1'b1);
        measure(1'b0, 1'b0, lat, nr, nsel, rf, rl);
        chk("p12_latency", lat, 13);
        chk("p12_rounds", nr, 12);
        chk("p12_selects", nsel, 1);
        chk("p12_first", rf, 4'd0);
        chk("p12_last", rl, 4'd11);
        @(posedge clk); #1;
        chk("p12_idle_ready", bus.ready_o, 1'b1);

        // p6
        launch(1'b0);
        measure(1'b0, 1'b0, lat, nr, nsel, rf, rl);
        chk("p6_latency", lat, 7);
        chk("p6_rounds", nr, 6);
        chk("p6_selects", nsel, 1);
        chk("p6_first", rf, 4'd6);
        chk("p6_last", rl, 4'd11);
        @(posedge clk); #1;

        // start/mode activity mid-run is ignored
        launch(1'b1);
        measure(1'b1, 1'b0, lat, nr, nsel, rf, rl);
        chk("busy_latency", lat, 13);
        chk("busy_rounds", nr, 12);
        chk("busy_first", rf, 4'd0);
        @(posedge clk); #1;

        // back-to-back: p12 then p6 accepted in the done cycle
        launch(1'b1);
        measure(1'b0, 1'b1, lat, nr, nsel, rf, rl);
        chk("b2b_p12_latency", lat, 13);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk("b2b_round", bus.round_o, 4'd6);
        chk("b2b_select", bus.select_o, 1'b1);
        chk("b2b_ready", bus.ready_o, 1'b0);
        measure(1'b0, 1'b0, lat, nr, nsel, rf, rl);
        chk("b2b_p6_latency", lat, 7);
        chk("b2b_p6_rounds", nr, 6);
        @(posedge clk); #1;

        // abort at round 5
        launch(1'b1);
        for (int i = 0; i < 20 && bus.round_o != 4'd5; i++) begin @(posedge clk); #1; end
        chk("abort_reach", bus.round_o, 4'd5);
        #1 rst = 1'b1;
        #1;
        chk("abort_ready", bus.ready_o, 1'b1);
        chk("abort_enable", bus.enable_o, 1'b0);
        chk("abort_done", bus.done_o, 1'b0);
        chk("abort_round", bus.round_o, 4'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        launch(1'b0);
        measure(1'b0, 1'b0, lat, nr, nsel, rf, rl);
        chk("post_abort_latency", lat, 7);
        chk("post_abort_first", rf, 4'd6);
        repeat (3) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/permutation_ctrl.md
Name: permutation_ctrl

Overview:
Sequencing controller placed directly upstream of the permutation datapath (mux + round function + state register). It accepts a start request with a mode selecting the p12 or p6 variant. It then drives the datapath's init-select, register-enable and 4-bit round-index inputs cycle by cycle, and signals completion with a one-cycle done pulse. It is the block the top-level ASCON128 FSM talks to instead of driving round indices directly.

Parameters:
- ROUND_LAST, 11, index of the final round for both variants.
- NB_ROUNDS_A, 12, round count for p12 (init and finalization); first index is ROUND_LAST+1-NB_ROUNDS_A = 0.
- NB_ROUNDS_B, 6, round count for p6 (data phase); first index is ROUND_LAST+1-NB_ROUNDS_B = 6.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only when ready_o=1.
- mode_i  in  1  1 = p12, 0 = p6; sampled with start_i.
- ready_o  out  1  controller can accept start_i.
- select_o  out  1  to datapath init select; 1 = load external state (first round only), 0 = feedback.
- enable_o  out  1  to datapath state-register enable.
- round_o  out  4  to datapath round index.
- done_o  out  1  one-cycle pulse; result is present at the datapath output.

Behaviour:
- Reset (async, active-high) forces state IDLE and round counter 0.
  - Reset values: ready_o=1, select_o=0, enable_o=0, round_o=0, done_o=0.
  - Reset asserted mid-run aborts immediately, with no done pulse; the state register contents are don't-care.
- All outputs are decoded from registered state and counter only; there is no combinational path from start_i or mode_i to any output.
- FSM states:
  - IDLE: ready_o=1. Edge with start_i=1 loads the counter with 0 (mode_i=1) or 6 (mode_i=0), then goes to FIRST.
  - FIRST: select_o=1, enable_o=1, round_o=counter. At the edge, the datapath latches round(counter) of the external state. Counter increments; go to RUN.
  - RUN: select_o=0, enable_o=1, round_o=counter. At the edge, the datapath latches the next round. If counter==ROUND_LAST, go to DONE; otherwise increment.
  - DONE: done_o=1, enable_o=0, ready_o=1; the result is held in the datapath register.
    - start_i=1 reloads the counter and goes to FIRST (back-to-back operation).
    - Otherwise go to IDLE.
- If the first index equals ROUND_LAST (degenerate one-round config), FIRST goes straight to DONE.
- Latency from the edge that accepts start to the done_o cycle: p12 = 13 cycles (rounds in cycles 1..12, done in 13); p6 = 7 cycles.
- start_i in FIRST or RUN is ignored; it is neither queued nor allowed to perturb the counter.
- mode_i is latched only at acceptance; changes mid-run have no effect.
- round_o never exceeds ROUND_LAST. The counter saturates rather than wrapping; reaching value 12 is an assertion error.
- enable_o=0 in IDLE and DONE, so the datapath register holds its value until the next start.

Decomposition:
- ascon_pack additions:
  - enum type_perm_state {IDLE, FIRST, RUN, DONE}.
  - Constants ROUND_LAST=4'd11, ROUND_A_START=4'd0, ROUND_B_START=4'd6.
  - Typedef type_round = logic[3:0].
- One sub-module, round_counter: 4-bit register with asynchronous active-high reset, load_i/load_val_i, en_i increment, and last_o flag (count==ROUND_LAST). The FSM stays in permutation_ctrl.

Test Plan:
1. Reset: assert reset_i mid-cycle with no clock edge -> outputs are immediately ready_o=1, select_o=0, enable_o=0, round_o=0, done_o=0.
2. p12: start_i=1, mode_i=1 for one cycle -> next cycle select_o=1, round_o=0; rounds 1..11 follow with select_o=0, enable_o=1; done_o=1 exactly in cycle 13, then IDLE.
3. p6: start_i=1, mode_i=0 -> round_o sequence 6,7,8,9,10,11 with select_o=1 only on 6; done_o in cycle 7. Paired with the datapath, the state matches the golden p6 output.
4. Busy ignore: pulse start_i and toggle mode_i at round_o=4 of a p12 run -> sequence and done timing unchanged from scenario 2.
5. Back-to-back: hold start_i=1, mode_i=0 during the done cycle of a p12 run -> next cycle FIRST with round_o=6; no IDLE gap.
6. Abort: assert reset_i while round_o=5 -> immediate IDLE with no done_o. A fresh p6 start then completes normally in 7 cycles.
